// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Clock-enable generator for the timer counter. Emits a
//                one-cycle tick every 2^(cks+1) pclk cycles, or one tick per
//                rising edge of a synchronised external clock. Ratio changes
//                take effect only at a period boundary, so no period is ever
//                shortened or stretched.
//
//  Ports       : pclk       - system clock, all state on rising edge
//                preset     - synchronous active-high reset
//                en         - run enable
//                cks        - ratio select, divide by 2^(cks+1)
//                ext_sel    - 0 = internal prescaler, 1 = external clock
//                ext_clk    - asynchronous external clock
//                tick       - registered one-cycle count enable
//                cks_active - ratio currently in effect
//                ext_active - registered copy of ext_sel
//
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 2**SEL_W
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             en,
    input  logic [SEL_W-1:0] cks,
    input  logic             ext_sel,
    input  logic             ext_clk,
    output logic             tick,
    output logic [SEL_W-1:0] cks_active,
    output logic             ext_active
);

    localparam logic [CNT_W-1:0] c_ALL_ONES = '1;
    localparam logic [SEL_W-1:0] c_TOP_SEL  = SEL_W'(CNT_W - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [SEL_W-1:0] r_cks_active;
    logic             r_ext_active;
    logic             r_sync0;
    logic             r_sync1;
    logic             r_sync2;

    logic [CNT_W-1:0] w_mask;
    logic             w_terminal;
    logic             w_switch;
    logic             w_ext_rise;

    // mask has (cks_active+1) low-order ones: shifting an all-ones word right
    // by (CNT_W-1-cks_active) keeps exactly that many.
    assign w_mask     = c_ALL_ONES >> (c_TOP_SEL - r_cks_active);
    assign w_terminal = ((r_cnt & w_mask) == w_mask);
    assign w_switch   = (ext_sel != r_ext_active);
    assign w_ext_rise = r_sync1 & ~r_sync2;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cnt        <= '0;
            r_tick       <= 1'b0;
            r_cks_active <= '0;
            r_ext_active <= 1'b0;
            r_sync0      <= 1'b0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
        end else begin
            // Synchroniser and edge register run in every mode so an edge
            // seen just before a switch to external mode is not lost.
            r_sync0      <= ext_clk;
            r_sync1      <= r_sync0;
            r_sync2      <= r_sync1;
            r_ext_active <= ext_sel;

            // Ratio register: follows cks freely while stopped, otherwise
            // only at an internal terminal count so the running period
            // completes at its original length.
            if (!en) begin
                r_cks_active <= cks;
            end else if (!r_ext_active && w_terminal && (cks != r_cks_active)) begin
                r_cks_active <= cks;
            end

            if (w_switch || !en) begin
                // Source switch or stop: suppress any tick and restart the
                // period from zero.
                r_tick <= 1'b0;
                r_cnt  <= '0;
            end else if (r_ext_active) begin
                r_tick <= w_ext_rise;
                r_cnt  <= '0;
            end else if (w_terminal) begin
                r_tick <= 1'b1;
                // A pending ratio change starts its first period from zero
                // so that period is full length.
                if (cks != r_cks_active) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_tick <= 1'b0;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign tick       = r_tick;
    assign cks_active = r_cks_active;
    assign ext_active = r_ext_active;

endmodule
`default_nettype wire

// File: tb/tb_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_prescaler
//  Description : Self-checking bench for timer_prescaler. A reference model
//                tracks the position inside the current tick period and the
//                recent history of sampled ext_clk values, and every output
//                is compared after each pclk edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_prescaler;

    logic       pclk = 1'b0;
    logic       preset;
    logic       en;
    logic [1:0] cks;
    logic       ext_sel;
    logic       ext_clk;
    logic       tick;
    logic [1:0] cks_active;
    logic       ext_active;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_k    = 0;   // ratio in effect
    int   m_pos  = 0;   // edges elapsed in the current period
    logic m_ext  = 0;
    logic m_tick = 0;
    logic h_prev1 = 0;  // ext_clk sampled 1 edge ago
    logic h_prev2 = 0;  // 2 edges ago
    logic h_prev3 = 0;  // 3 edges ago

    int tick_cnt;

    timer_prescaler #(.SEL_W(2)) dut (
        .pclk       (pclk),
        .preset     (preset),
        .en         (en),
        .cks        (cks),
        .ext_sel    (ext_sel),
        .ext_clk    (ext_clk),
        .tick       (tick),
        .cks_active (cks_active),
        .ext_active (ext_active)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies one pclk edge of the specified behaviour to the model.
    task automatic model_edge();
        int   period;
        logic old_ext;
        logic ext_edge;
        logic at_end;
        if (preset) begin
            m_k = 0; m_pos = 0; m_ext = 0; m_tick = 0;
            h_prev1 = 0; h_prev2 = 0; h_prev3 = 0;
        end else begin
            period   = 1 << (m_k + 1);
            at_end   = (m_pos == period - 1);
            ext_edge = h_prev2 & ~h_prev3;
            old_ext  = m_ext;
            m_ext    = ext_sel;
            if (ext_sel != old_ext) begin
                m_tick = 0;
                m_pos  = 0;
                if (!en) m_k = int'(cks);
                else if (!old_ext && at_end && int'(cks) != m_k) m_k = int'(cks);
            end else if (!en) begin
                m_tick = 0; m_pos = 0; m_k = int'(cks);
            end else if (old_ext) begin
                m_tick = ext_edge; m_pos = 0;
            end else if (at_end) begin
                m_tick = 1;
                m_pos  = 0;
                if (int'(cks) != m_k) m_k = int'(cks);
            end else begin
                m_tick = 0;
                m_pos++;
            end
            h_prev3 = h_prev2;
            h_prev2 = h_prev1;
            h_prev1 = ext_clk;
        end
    endtask

    task automatic step();
        @(posedge pclk);
        model_edge();
        #1;
        check("tick", 8'(tick), 8'(m_tick));
        check("cks_active", 8'(cks_active), 8'(m_k));
        check("ext_active", 8'(ext_active), 8'(m_ext));
        if (tick === 1'b1) tick_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int hold;
        tick_cnt = 0;
        preset = 1; en = 1; cks = 2'd3; ext_sel = 0; ext_clk = 0;

        // 1: reset held with activity on the inputs, then release at ratio 2
        for (int i = 0; i < 3; i++) begin
            ext_clk = ~ext_clk;
            step();
        end
        check("reset_tick", 8'(tick), 8'd0);
        check("reset_cks", 8'(cks_active), 8'd0);
        preset = 0; cks = 2'd0; ext_clk = 0;
        tick_cnt = 0;
        run(8);
        check("t1_ticks", 8'(tick_cnt), 8'd4);

        // 2: ratio 8 for 40 cycles, then change to 16
        en = 0; cks = 2'd2; step();
        en = 1; tick_cnt = 0;
        run(40);
        check("t2_ticks", 8'(tick_cnt), 8'd5);
        cks = 2'd3;
        run(40);
        check("t2_cks", 8'(cks_active), 8'd3);

        // 3: mid-period change from 8 down to 2
        en = 0; cks = 2'd2; step();
        en = 1; run(3);
        cks = 2'd0;
        tick_cnt = 0;
        run(5);
        check("t3_first", 8'(tick_cnt), 8'd1);
        check("t3_cks", 8'(cks_active), 8'd0);
        run(8);

        // 4: stop mid-period while the ratio changes
        en = 0; cks = 2'd1; step();
        en = 1; run(3);
        en = 0; cks = 2'd3; tick_cnt = 0;
        run(5);
        check("t4_noticks", 8'(tick_cnt), 8'd0);
        check("t4_cks", 8'(cks_active), 8'd3);
        en = 1;
        run(15);
        check("t4_early", 8'(tick_cnt), 8'd0);
        run(33);
        check("t4_ticks", 8'(tick_cnt), 8'd3);

        // 5: external clock, 4 high / 4 low, 10 periods
        ext_sel = 1; tick_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            ext_clk = ((i % 8) < 4);
            step();
        end
        check("t5_ext_ticks", 8'(tick_cnt), 8'd10);
        ext_sel = 0; ext_clk = 1;
        step();
        check("t5_switch_tick", 8'(tick), 8'd0);
        for (int i = 1; i < 24; i++) begin
            ext_clk = ((i % 8) < 4);
            step();
        end

        // 6: reset in the middle of a long period
        en = 0; cks = 2'd3; step();
        en = 1; run(5);
        preset = 1; step();
        check("t6_tick", 8'(tick), 8'd0);
        check("t6_cks", 8'(cks_active), 8'd0);
        preset = 0; cks = 2'd0;
        run(10);
        cks = 2'd2;
        run(20);

        // Random stimulus
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            preset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 14) == 0) cks = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) ext_sel = ~ext_sel;
            if (hold >= 2 && $urandom_range(0, 2) == 0) begin
                ext_clk = ~ext_clk;
                hold = 0;
            end else begin
                hold++;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
